uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo_if.sv | 26 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_tx_fifo.sv | 131 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding and frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // 8N1: start + 8 data + stop
  localparam int FRAME_BITS = 10;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Register-side write port and status/serial outputs of the buffered UART transmitter.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
);
  logic                          wr_en;
  logic [7:0]                    wr_data;
  logic [DIV_WIDTH-1:0]          divisor;
  logic                          clr_overflow;
  logic                          tx;
  logic                          busy;
  logic                          full;
  logic                          empty;
  logic                          overflow;
  logic [$clog2(FIFO_DEPTH):0]   count;

  modport master (
    output wr_en, wr_data, divisor, clr_overflow,
    input  tx, busy, full, empty, overflow, count
  );

  modport slave (
    input  wr_en, wr_data, divisor, clr_overflow,
    output tx, busy, full, empty, overflow, count
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count and same-cycle push+pop.
// Caller guarantees push only when not full (or popping) and pop only when not empty.
module sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  // Head of queue is visible combinationally so a pop can load it on the same edge.
  assign rdata = mem[rd_ptr];

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally (power-of-two depth); flags tracked alongside count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10: begin
          count <= count + 1'b1;
          full  <= (count == CW'(DEPTH - 1));
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
          empty <= (count == CW'(1));
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: FIFO front end, bit timer, shift register and FSM.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input logic          clk,
  input logic          reset,
  uart_tx_fifo_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e              state_q, state_nx;
  logic [DIV_WIDTH-1:0]   div_q, timer_q;
  logic [BIT_CNT_W-1:0]   bit_q;
  logic [7:0]             shreg_q, rd_data;
  logic                   tx_q, tx_nx, busy_q, ovf_q;
  logic                   push, pop, drop, bit_end, last_data;
  logic                   f_full, f_empty;
  logic [CW-1:0]          f_count, count_nx;

  assign bit_end   = (timer_q == '0);
  assign last_data = (bit_q == BIT_CNT_W'(FRAME_BITS - 2));
  // A write into a full FIFO survives only if the head leaves on the same edge.
  assign push      = bus.wr_en && (!f_full || pop);
  assign drop      = bus.wr_en && f_full && !pop;

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.wr_data),
    .rdata (rd_data),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_nx;
  end

  // Next state: each non-idle state advances at the end of its bit period.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE:  if (!f_empty)              state_nx = ST_START;
      ST_START: if (bit_end)               state_nx = ST_DATA;
      ST_DATA:  if (bit_end && last_data)  state_nx = ST_STOP;
      ST_STOP:  if (bit_end)               state_nx = f_empty ? ST_IDLE : ST_START;
      default:                             state_nx = ST_IDLE;
    endcase
  end

  // Outputs: pop strobe and next serial level; a pop always starts a start bit.
  always_comb begin
    pop   = 1'b0;
    tx_nx = tx_q;
    case (state_q)
      ST_IDLE: begin
        tx_nx = 1'b1;
        if (!f_empty) begin
          pop   = 1'b1;
          tx_nx = 1'b0;
        end
      end
      ST_START: if (bit_end) tx_nx = shreg_q[0];
      ST_DATA:  if (bit_end) tx_nx = last_data ? 1'b1 : shreg_q[1];
      ST_STOP: begin
        if (bit_end) begin
          pop   = !f_empty;
          tx_nx = f_empty;
        end
      end
      default: tx_nx = 1'b1;
    endcase
  end

  // Occupancy after this edge, used to register busy without a comb output path.
  always_comb begin
    count_nx = f_count;
    case ({push, pop})
      2'b10:   count_nx = f_count + 1'b1;
      2'b01:   count_nx = f_count - 1'b1;
      default: count_nx = f_count;
    endcase
  end

  // Datapath: divisor latched per frame, timer reloads each bit, LSB-first shifter.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      div_q   <= '0;
      timer_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      tx_q   <= tx_nx;
      busy_q <= (state_nx != ST_IDLE) || (count_nx != '0);
      if (drop)                  ovf_q <= 1'b1;
      else if (bus.clr_overflow) ovf_q <= 1'b0;
      if (pop) begin
        div_q   <= bus.divisor;
        timer_q <= bus.divisor;
        bit_q   <= '0;
        shreg_q <= rd_data;
      end else if (state_q != ST_IDLE) begin
        if (bit_end) begin
          timer_q <= div_q;
          bit_q   <= bit_q + 1'b1;
          if (state_q == ST_DATA) shreg_q <= shreg_q >> 1;
        end else begin
          timer_q <= timer_q - 1'b1;
        end
      end
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.full     = f_full;
  assign bus.empty    = f_empty;
  assign bus.count    = f_count;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, every cycle compared
// against a frame-level model (byte queue + queue of expected per-cycle line levels).
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic reset;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) bus();

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: queued bytes, remaining line levels of the current frame, sticky flag.
  byte unsigned m_q[$];
  bit           plan[$];
  bit           m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int  pre;
    bit  pop;
    bit  drop;
    byte unsigned b;
    int  bp;
    pre = m_q.size();
    if (reset) begin
      m_q.delete();
      plan.delete();
      m_ovf = 1'b0;
    end else begin
      if (plan.size() > 0) void'(plan.pop_front());
      pop = (plan.size() == 0) && (pre > 0);
      if (pop) begin
        b  = m_q.pop_front();
        bp = int'(bus.divisor) + 1;
        for (int k = 0; k < 10; k++) begin
          for (int c = 0; c < bp; c++) begin
            if (k == 0)      plan.push_back(1'b0);
            else if (k == 9) plan.push_back(1'b1);
            else             plan.push_back(b[k-1]);
          end
        end
      end
      drop = bus.wr_en && (pre == DEPTH) && !pop;
      if (bus.wr_en && !drop) m_q.push_back(bus.wr_data);
      if (drop)                  m_ovf = 1'b1;
      else if (bus.clr_overflow) m_ovf = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("tx",       bus.tx,       (plan.size() > 0) ? plan[0] : 1'b1);
    chk("busy",     bus.busy,     (plan.size() > 0) || (m_q.size() > 0));
    chk("full",     bus.full,     m_q.size() == DEPTH);
    chk("empty",    bus.empty,    m_q.size() == 0);
    chk("count",    bus.count,    m_q.size());
    chk("overflow", bus.overflow, m_ovf);
  endtask

  // One clock: inputs already driven; model and DUT both take the edge, then compare.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    bus.wr_en        = 1'b0;
    bus.clr_overflow = 1'b0;
    reset            = 1'b0;
  endtask

  task automatic wr(input byte unsigned d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
  endtask

  initial begin
    int nb;
    bus.wr_en        = 1'b0;
    bus.wr_data      = 8'h00;
    bus.divisor      = 16'd3;
    bus.clr_overflow = 1'b0;
    reset            = 1'b1;
    cycle();
    chk("rst_tx",    bus.tx,       1);
    chk("rst_busy",  bus.busy,     0);
    chk("rst_empty", bus.empty,    1);
    chk("rst_full",  bus.full,     0);
    chk("rst_count", bus.count,    0);
    chk("rst_ovf",   bus.overflow, 0);

    // Single byte 0xA5 at divisor 3: 40-cycle frame, busy for 41 samples from the write.
    bus.divisor = 16'd3;
    wr(8'hA5);
    nb = int'(bus.busy);
    for (int i = 0; i < 45; i++) begin
      cycle();
      nb += int'(bus.busy);
    end
    chk("a5_busy_len", nb, 41);

    // Three bytes back to back at divisor 0: contiguous 10-cycle frames.
    bus.divisor = 16'd0;
    wr(8'h01);
    nb = int'(bus.busy);
    wr(8'h80);
    nb += int'(bus.busy);
    wr(8'hFF);
    nb += int'(bus.busy);
    for (int i = 0; i < 35; i++) begin
      cycle();
      nb += int'(bus.busy);
    end
    chk("b2b_busy_len", nb, 31);

    // Six writes into a depth-4 FIFO: one popped, four queued, last dropped.
    bus.divisor = 16'd9;
    for (int i = 0; i < 6; i++) wr(8'h10 + 8'(i));
    chk("ovf_set",   bus.overflow, 1);
    chk("ovf_count", bus.count,    4);
    bus.clr_overflow = 1'b1;
    cycle();
    chk("ovf_clr", bus.overflow, 0);
    idle(520);

    // Full FIFO with a write landing exactly on the pop edge.
    bus.divisor = 16'd2;
    for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i));
    chk("pp_full", bus.full, 1);
    for (int i = 0; i < 200 && plan.size() != 1; i++) cycle();
    wr(8'h99);
    chk("pp_count", bus.count,    4);
    chk("pp_ovf",   bus.overflow, 0);
    idle(170);

    // Reset mid-frame (third data bit of 0x5A) with two bytes queued.
    bus.divisor = 16'd1;
    wr(8'h5A);
    wr(8'h11);
    wr(8'h22);
    for (int i = 0; i < 40 && plan.size() != 13; i++) cycle();
    do_reset();
    chk("mr_tx",    bus.tx,    1);
    chk("mr_empty", bus.empty, 1);
    chk("mr_count", bus.count, 0);
    chk("mr_busy",  bus.busy,  0);
    idle(30);

    // Divisor change mid-frame affects only the following frame.
    bus.divisor = 16'd3;
    wr(8'hC3);
    wr(8'h3C);
    idle(10);
    bus.divisor = 16'd7;
    idle(130);

    // Random traffic, divisor churn, occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.divisor = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'($urandom);
      end
      if ($urandom_range(0, 19) == 0)  bus.clr_overflow = 1'b1;
      if ($urandom_range(0, 499) == 0) reset = 1'b1;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
